// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the control decoder.
package instr_fetch_pkg;

    // Fetch FSM states; at most one memory request is ever outstanding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes, shared with the control decoder.
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LW     = 7'b0000011;
    localparam logic [6:0] OPC_SW     = 7'b0100011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Force a target address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: reset load, sequential +4 advance and word-aligned redirect.
module fetch_pc
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        align_err
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        align_err_q;
    logic        align_err_d;

    // Redirect wins over sequential advance; +4 wraps naturally at 2^32.
    always_comb begin
        pc_d        = pc_q;
        align_err_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (advance) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC and misalignment flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc        = pc_q;
    assign align_err = align_err_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory fetch with stall and redirect.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic        align_err
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  instr_q;
    logic [31:0]  instr_d;
    logic [31:0]  instr_pc_q;
    logic [31:0]  instr_pc_d;
    logic [31:0]  pc;
    logic         advance;
    logic         capture;

    // Consumption advances the PC; a response is kept only if no redirect coincides.
    assign advance = (state_q == ST_VALID) && !stall;
    assign capture = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk            (clk),
        .reset          (reset),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .align_err      (align_err)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect with a response still in flight goes to DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
                end else if (imem_rvalid) begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (redirect_valid || !stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        instr_valid = (state_q == ST_VALID);
        imem_addr   = pc;
    end

    // Instruction capture path: only a WAIT-state response updates instr/instr_pc.
    always_comb begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (capture) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
        end
    end

    // Instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign instr    = instr_q;
    assign instr_pc = instr_pc_q;
    assign opcode   = instr_q[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand sequences, random run.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        reset, imem_req, imem_rvalid, redirect_valid, stall, instr_valid, align_err;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
    logic [6:0]  opcode;

    // Wrap-around DUT (RESET_PC = FFFF_FFFC)
    logic        w_reset, w_imem_req, w_imem_rvalid, w_redirect_valid, w_stall, w_instr_valid, w_align_err;
    logic [31:0] w_imem_addr, w_imem_rdata, w_redirect_pc, w_instr, w_instr_pc;
    logic [6:0]  w_opcode;

    instr_fetch u_dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .align_err(align_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(w_reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .imem_rvalid(w_imem_rvalid),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .stall(w_stall),
        .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
        .opcode(w_opcode), .align_err(w_align_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] rpc, input logic stl);
        reset          = rst;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        stall          = stl;
    endtask

    // Memory contents used by the random run.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        logic        stl;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic        e_align;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic redir,
                                input logic [31:0] rpc, input logic stl, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_ipc, input logic [31:0] e_instr,
                                input logic e_align);
        vec_t v;
        v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc; v.stl = stl;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_ipc = e_ipc; v.e_instr = e_instr; v.e_align = e_align;
        return v;
    endfunction

    // Random-run reference: transaction-level view of fetch order and discards.
    bit          m_valid, m_align, o_busy, o_stale, delivered, valid_now, redir_r, stl_r, rv_r;
    logic [31:0] m_pc, m_ipc, o_addr, pc_old, rpc_r, rd_r, exp_word;
    int          o_due, cyc, consumed, idle_run;

    initial begin
        w_reset = 1'b1; w_imem_rvalid = 1'b0; w_imem_rdata = 32'h0;
        w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_stall = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        // c0: reset state
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_align", {31'h0, align_err}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_opcode", {25'h0, opcode}, 32'h0);

        // Directed table, rows c1..c17
        //                rv rdata         rd rpc          st req addr        val ipc          instr        al
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 1, 32'h0,       0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(1, 32'h00500093, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       1, 0, 32'h0,       1, 32'h0,       32'h00500093, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       1, 0, 32'h0,       1, 32'h0,       32'h00500093, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       1, 0, 32'h0,       1, 32'h0,       32'h00500093, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 0, 32'h0,       1, 32'h0,       32'h00500093, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 1, 32'h4,       0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(0, 32'h0,        1, 32'h100,     0, 0, 32'h0,       0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 0, 32'h0,       0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(1, 32'hDEADBEEF, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 1, 32'h100,     0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(1, 32'h00000063, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(0, 32'h0,        1, 32'h102,     0, 0, 32'h0,       1, 32'h100,     32'h00000063, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 1, 32'h100,     0, 32'h0,       32'h0,       1));
        vecs.push_back(mk(1, 32'h0000206F, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,       32'h0,       0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 0, 32'h0,       1, 32'h100,     32'h0000206F, 0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,       0, 1, 32'h104,     0, 32'h0,       32'h0,       0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(1'b0, vecs[i].rv, vecs[i].rd, vecs[i].redir, vecs[i].rpc, vecs[i].stl);
            chk($sformatf("vec%0d_req", i + 1), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i + 1), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i + 1), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                exp_word = vecs[i].e_instr;
                chk($sformatf("vec%0d_ipc", i + 1), instr_pc, vecs[i].e_ipc);
                chk($sformatf("vec%0d_instr", i + 1), instr, exp_word);
                chk($sformatf("vec%0d_opcode", i + 1), {25'h0, opcode}, {25'h0, exp_word[6:0]});
            end
            chk($sformatf("vec%0d_align", i + 1), {31'h0, align_err}, {31'h0, vecs[i].e_align});
        end

        // Reset in WAIT with the response arriving the next cycle
        @(posedge clk); #1;                       // c18: WAIT
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rstwait_wait_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;                       // c19: IDLE after reset
        drive(1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0);
        chk("rstwait_req", {31'h0, imem_req}, 32'h0);
        chk("rstwait_valid", {31'h0, instr_valid}, 32'h0);
        chk("rstwait_instr", instr, 32'h0);
        chk("rstwait_instr_pc", instr_pc, 32'h0);
        @(posedge clk); #1;                       // c20: FETCH at RESET_PC
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rstwait_refetch_req", {31'h0, imem_req}, 32'h1);
        chk("rstwait_refetch_addr", imem_addr, 32'h0);
        @(posedge clk); #1;                       // c21: WAIT, stale data not captured
        drive(1'b0, 1'b1, 32'h00002003, 1'b0, 32'h0, 1'b0);
        chk("rstwait_no_valid", {31'h0, instr_valid}, 32'h0);
        @(posedge clk); #1;                       // c22: VALID with LW
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rstwait_valid2", {31'h0, instr_valid}, 32'h1);
        chk("rstwait_instr2", instr, 32'h00002003);
        chk("rstwait_opcode2", {25'h0, opcode}, {25'h0, OPC_LW});

        // PC wrap from RESET_PC = FFFF_FFFC
        @(posedge clk); #1;
        w_reset = 1'b0;
        @(posedge clk); #1;
        chk("wrap_req0", {31'h0, w_imem_req}, 32'h1);
        chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        w_imem_rvalid = 1'b1; w_imem_rdata = 32'h0000_0033;
        @(posedge clk); #1;
        w_imem_rvalid = 1'b0;
        chk("wrap_valid", {31'h0, w_instr_valid}, 32'h1);
        chk("wrap_ipc", w_instr_pc, 32'hFFFF_FFFC);
        chk("wrap_opcode", {25'h0, w_opcode}, {25'h0, OPC_RTYPE});
        @(posedge clk); #1;
        chk("wrap_req1", {31'h0, w_imem_req}, 32'h1);
        chk("wrap_addr1", w_imem_addr, 32'h0000_0000);

        // Randomized run against the transaction-level reference
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        m_valid = 0; m_align = 0; o_busy = 0; o_stale = 0;
        m_pc = 32'h0; m_ipc = 32'h0; o_addr = 32'h0; o_due = 0;
        cyc = 0; consumed = 0; idle_run = 0;
        for (int n = 0; n < 3000; n++) begin
            chk("rand_valid", {31'h0, instr_valid}, {31'h0, m_valid});
            if (m_valid) begin
                exp_word = memw(m_ipc);
                chk("rand_ipc", instr_pc, m_ipc);
                chk("rand_instr", instr, exp_word);
                chk("rand_opcode", {25'h0, opcode}, {25'h0, exp_word[6:0]});
            end
            chk("rand_align", {31'h0, align_err}, {31'h0, m_align});
            if (o_busy || m_valid) chk("rand_no_extra_req", {31'h0, imem_req}, 32'h0);
            if (imem_req) chk("rand_addr", imem_addr, m_pc);
            if (!imem_req && !m_valid && !o_busy) idle_run++; else idle_run = 0;
            if (idle_run > 2) begin
                n_checks++; n_fail++;
                $display("FAIL rand_progress: no fetch for %0d cycles, required at most 2", idle_run);
                idle_run = 0;
            end

            redir_r = ($urandom_range(0, 9) == 0);
            rpc_r   = $urandom;
            if ($urandom_range(0, 2) != 0) rpc_r[1:0] = 2'b00;
            stl_r   = ($urandom_range(0, 2) == 0);
            delivered = 0;
            rd_r = $urandom;
            if (o_busy && cyc == o_due) begin
                rv_r = 1; rd_r = memw(o_addr); delivered = 1;
            end else begin
                rv_r = (!o_busy && $urandom_range(0, 5) == 0);
            end
            drive(1'b0, rv_r, rd_r, redir_r, rpc_r, stl_r);

            pc_old    = m_pc;
            valid_now = m_valid;
            m_align   = redir_r && (rpc_r[1:0] != 2'b00);
            if (valid_now) begin
                if (redir_r) m_valid = 0;
                else if (!stl_r) begin m_valid = 0; m_pc = m_pc + 32'd4; consumed++; end
            end
            if (delivered) begin
                o_busy = 0;
                if (!o_stale && !redir_r) begin m_valid = 1; m_ipc = o_addr; end
            end
            if (redir_r) begin m_pc = {rpc_r[31:2], 2'b00}; o_stale = 1; end
            if (imem_req) begin
                o_busy = 1; o_addr = pc_old; o_stale = redir_r;
                o_due = cyc + 1 + $urandom_range(0, 3);
            end
            cyc++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (consumed < 50) begin
            n_fail++;
            $display("FAIL rand_throughput: consumed %0d instructions, required at least 50", consumed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
